// File: rtl/regfile_access_ctrl.sv
// Request sequencer/arbiter for the 16x32 register file: read A, read B, ALU wait, one-hot writeback.
// Optional RR_ARB_EN selects round-robin arbitration; default is fixed priority to requester 0.
module regfile_access_ctrl #(
    parameter int unsigned NREG     = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned DW       = 32,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*AW-1:0] req_ra,
    input  logic [2*AW-1:0] req_rb,
    input  logic [2*AW-1:0] req_rc,
    input  logic [1:0]      req_we,
    input  logic [1:0]      req_ba,
    output logic [AW-1:0]   rsel,
    output logic            BAout,
    input  logic [DW-1:0]   rdata,
    output logic [DW-1:0]   opa,
    output logic [DW-1:0]   opb,
    output logic            op_valid,
    input  logic            res_valid,
    input  logic [DW-1:0]   res_data,
    output logic [NREG-1:0] write,
    output logic [DW-1:0]   D,
    output logic            done,
    output logic            done_id,
    output logic            timeout,
    output logic            busy
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB, DONE} state_t;

    state_t          state;
    logic [AW-1:0]   rb_q;
    logic [AW-1:0]   rc_q;
    logic            we_q;
    logic            id_q;
    logic [7:0]      cnt;
    logic [1:0]      grant;
    logic            win;
    logic [NREG-1:0] rc_onehot;

`ifdef RR_ARB_EN
    logic last_id;

    always_comb begin
        grant = 2'b00;
        if (req_valid == 2'b11)
            grant = last_id ? 2'b01 : 2'b10;
        else if (req_valid[0])
            grant = 2'b01;
        else if (req_valid[1])
            grant = 2'b10;
    end
`else
    always_comb begin
        grant = 2'b00;
        if (req_valid[0])
            grant = 2'b01;
        else if (req_valid[1])
            grant = 2'b10;
    end
`endif

    assign req_ready = (clr && state == IDLE) ? grant : 2'b00;
    assign win       = grant[1];
    assign busy      = (state != IDLE);

    always_comb begin
        rc_onehot       = '0;
        rc_onehot[rc_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            rb_q     <= '0;
            rc_q     <= '0;
            we_q     <= 1'b0;
            id_q     <= 1'b0;
            cnt      <= '0;
            rsel     <= '0;
            BAout    <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            op_valid <= 1'b0;
            write    <= '0;
            D        <= '0;
            done     <= 1'b0;
            done_id  <= 1'b0;
            timeout  <= 1'b0;
`ifdef RR_ARB_EN
            last_id  <= 1'b1;
`endif
        end else begin
            op_valid <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                IDLE: if (|req_ready) begin
                    // rsel/BAout are registered, so the A-side select is loaded straight from the winner
                    rsel  <= req_ra[int'(win)*AW +: AW];
                    BAout <= req_ba[win];
                    rb_q  <= req_rb[int'(win)*AW +: AW];
                    rc_q  <= req_rc[int'(win)*AW +: AW];
                    we_q  <= req_we[win];
                    id_q  <= win;
`ifdef RR_ARB_EN
                    last_id <= win;
`endif
                    state <= RD_A;
                end
                RD_A: begin
                    opa   <= rdata;
                    rsel  <= rb_q;
                    BAout <= 1'b0;
                    state <= RD_B;
                end
                RD_B: begin
                    opb      <= rdata;
                    op_valid <= 1'b1;
                    rsel     <= '0;
                    cnt      <= '0;
                    state    <= EXEC;
                end
                EXEC: begin
                    if (res_valid) begin
                        D <= res_data;
                        if (we_q) begin
                            write <= rc_onehot;
                            state <= WB;
                        end else begin
                            done    <= 1'b1;
                            done_id <= id_q;
                            state   <= DONE;
                        end
                    end else if (cnt == 8'(WAIT_MAX - 1)) begin
                        done    <= 1'b1;
                        done_id <= id_q;
                        timeout <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WB: begin
                    write   <= '0;
                    done    <= 1'b1;
                    done_id <= id_q;
                    state   <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural 16x32 register file and ALU stand-in.
module tb_regfile_access_ctrl;

    logic        clk;
    logic        clr;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_ra, req_rb, req_rc;
    logic [1:0]  req_we, req_ba;
    logic [3:0]  rsel;
    logic        BAout;
    logic [31:0] rdata, opa, opb, res_data, D;
    logic        op_valid, res_valid, done, done_id, timeout, busy;
    logic [15:0] write;

    logic [31:0] regs [16];
    logic        load;
    int          n_cmp;
    int          n_err;

    regfile_access_ctrl #(.NREG(16), .AW(4), .DW(32), .WAIT_MAX(4)) dut (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
        .req_ra(req_ra), .req_rb(req_rb), .req_rc(req_rc), .req_we(req_we), .req_ba(req_ba),
        .rsel(rsel), .BAout(BAout), .rdata(rdata), .opa(opa), .opb(opb), .op_valid(op_valid),
        .res_valid(res_valid), .res_data(res_data), .write(write), .D(D), .done(done),
        .done_id(done_id), .timeout(timeout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        case (i)
            0:       return 32'hDEAD;
            3:       return 32'h11;
            4:       return 32'h22;
            7:       return 32'h77;
            default: return 32'h1000 + i;
        endcase
    endfunction

    // Register file: R0 reads as zero only when BAout is high; writes land on negedge
    always @(negedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (load) regs[i] <= init_val(i);
            else if (write[i]) regs[i] <= D;
        end
    end

    assign rdata = (BAout && rsel == 4'd0) ? 32'h0 : regs[rsel];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input int id, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input logic we, input logic ba,
                         input logic [31:0] res);
        logic [31:0] ea, eb;
        ea = (ba && ra == 4'd0) ? 32'h0 : regs[ra];
        eb = regs[rb];
        @(negedge clk);
        req_valid = 2'(1 << id);
        req_ra = {ra, ra}; req_rb = {rb, rb}; req_rc = {rc, rc};
        req_we = {we, we}; req_ba = {ba, ba};
        #1 chk("req_ready", 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        req_valid = 2'b00;
        chk("rda_rsel", 32'(rsel), 32'(ra));
        chk("rda_ba", 32'(BAout), 32'(ba));
        chk("rda_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("rdb_rsel", 32'(rsel), 32'(rb));
        chk("rdb_ba", 32'(BAout), 32'd0);
        chk("opa", opa, ea);
        @(negedge clk);
        chk("op_valid", 32'(op_valid), 32'd1);
        chk("opb", opb, eb);
        chk("exec_rsel", 32'(rsel), 32'd0);
        res_valid = 1'b1; res_data = res;
        @(negedge clk);
        res_valid = 1'b0;
        chk("D", D, res);
        chk("op_valid_pulse", 32'(op_valid), 32'd0);
        if (we) begin
            chk("wb_write", 32'(write), 32'(1 << rc));
            @(negedge clk);
        end
        chk("done", 32'(done), 32'd1);
        chk("done_id", 32'(done_id), 32'(id));
        chk("done_tmo", 32'(timeout), 32'd0);
        chk("done_write", 32'(write), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("regs_rc", regs[rc], we ? res : init_val(int'(rc)));
    endtask

    initial begin
        int ids [2];
        int nd;
        n_cmp = 0; n_err = 0;
        clr = 1'b0; load = 1'b1;
        req_valid = '0; req_ra = '0; req_rb = '0; req_rc = '0; req_we = '0; req_ba = '0;
        res_valid = 1'b0; res_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_opa", opa, 32'd0);
        chk("rst_rsel", 32'(rsel), 32'd0);
        req_valid = 2'b11;
        #1 chk("rst_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        load = 1'b0;
        @(negedge clk);
        clr = 1'b1;

        do_op(0, 4'd3, 4'd4, 4'd5, 1'b1, 1'b0, 32'h33);
        do_op(1, 4'd0, 4'd3, 4'd6, 1'b1, 1'b1, 32'h44);
        do_op(0, 4'd0, 4'd4, 4'd9, 1'b0, 1'b0, 32'h7);
        do_op(0, 4'd5, 4'd5, 4'd5, 1'b1, 1'b0, 32'h99);

        // Timeout: no result ever arrives, WAIT_MAX=4
        @(negedge clk);
        req_valid = 2'b10; req_ra = 8'h34; req_rb = 8'h43; req_rc = 8'h88; req_we = 2'b11; req_ba = 2'b00;
        @(negedge clk);
        req_valid = 2'b00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("tmo_write", 32'(write), 32'd0);
            chk("tmo_early_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        chk("tmo_done", 32'(done), 32'd1);
        chk("tmo_flag", 32'(timeout), 32'd1);
        chk("tmo_id", 32'(done_id), 32'd1);
        chk("tmo_nowrite", 32'(write), 32'd0);
        @(negedge clk);
        chk("tmo_flag_pulse", 32'(timeout), 32'd0);
        chk("tmo_reg8", regs[8], init_val(8));

        // Reset while in WB
        req_valid = 2'b01; req_ra = 8'h03; req_rb = 8'h04; req_rc = 8'h07; req_we = 2'b01; req_ba = 2'b00;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        res_valid = 1'b1; res_data = 32'hAB;
        @(posedge clk);
        #1 res_valid = 1'b0;
        chk("wb_before_rst", 32'(write), 32'h80);
        clr = 1'b0;
        #1 chk("rst_wb_write", 32'(write), 32'd0);
        chk("rst_wb_busy", 32'(busy), 32'd0);
        chk("rst_wb_D", D, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_wb_reg7", regs[7], 32'h77);
        clr = 1'b1;

        // Both requesters held valid across two operations
        @(negedge clk);
        req_valid = 2'b11; req_ra = 8'h43; req_rb = 8'h34; req_rc = 8'h21; req_we = 2'b00;
        res_valid = 1'b1; res_data = 32'h5;
        nd = 0;
        for (int c = 0; c < 40 && nd < 2; c++) begin
            @(negedge clk);
            if (done) begin
                ids[nd] = int'(done_id);
                nd++;
            end
        end
        req_valid = 2'b00; res_valid = 1'b0;
        chk("arb_count", 32'(nd), 32'd2);
        if (nd == 2) begin
            chk("arb_first", 32'(ids[0]), 32'd0);
`ifdef RR_ARB_EN
            chk("arb_second", 32'(ids[1]), 32'd1);
`else
            chk("arb_second", 32'(ids[1]), 32'd0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Sequencer and arbiter for the 16x32 register file. It accepts register-operation requests from two requesters: requester 0 is the control unit, requester 1 is the debug/loader port. For each granted request it:
- reads two source registers through the file's read mux, one per cycle;
- hands both operands to the ALU and waits for the result;
- writes the result back using a one-hot write enable.

Parameters:
NREG, 16, number of registers, equal to the write one-hot width
AW, 4, register index width
DW, 32, data width
WAIT_MAX, 255, maximum EXEC cycles before timeout (max 255)

Ports:
clk  in  1  system clock; all state updates on posedge
clr  in  1  asynchronous, active-low reset
req_valid  in  2  request valid, one bit per requester
req_ready  out  2  request accepted, one-hot
req_ra  in  2*AW  source A index; requester n occupies bits [n*AW +: AW]
req_rb  in  2*AW  source B index, same packing
req_rc  in  2*AW  destination index, same packing
req_we  in  2  writeback enable per requester
req_ba  in  2  base-address mode per requester: R0 reads as zero for source A
rsel  out  AW  register file read-mux select
BAout  out  1  forces the R0 read to zero
rdata  in  DW  selected register value from the read mux
opa  out  DW  captured operand A
opb  out  DW  captured operand B
op_valid  out  1  one-cycle pulse: operands ready for the ALU
res_valid  in  1  ALU result valid
res_data  in  DW  ALU result
write  out  NREG  one-hot register write enable
D  out  DW  writeback data
done  out  1  one-cycle completion pulse
done_id  out  1  requester that owns the completion
timeout  out  1  asserted together with done when EXEC timed out
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (clr=0, asynchronous) forces:
  - state=IDLE;
  - write, opa, opb, D, rsel = 0;
  - op_valid, done, done_id, timeout, BAout, req_ready = 0;
  - any in-flight operation is dropped and no write occurs.
- IDLE:
  - req_ready is combinational: the one-hot grant among req_valid bits; requester 0 wins if both are valid.
  - On a posedge with req_valid&req_ready, latch ra/rb/rc/we/ba of the winner plus its id, then go to RD_A.
- RD_A: rsel=ra, BAout=ba. On the posedge, opa<=rdata. Next state RD_B.
- RD_B: rsel=rb, BAout=0. On the posedge, opb<=rdata and op_valid<=1 for one cycle. Next state EXEC.
- EXEC:
  - On entry, clear the wait counter; it increments each cycle without res_valid.
  - res_valid=1: D<=res_data, then go to WB if we=1, else DONE.
  - The counter reaching WAIT_MAX with no res_valid sets a timeout flag and goes to DONE; no writeback.
  - res_valid in any other state is ignored.
- WB:
  - write = one-hot of rc for exactly one cycle, with D stable for the whole cycle.
  - The register file samples on negedge inside this cycle.
  - Next state DONE.
- DONE: done=1, done_id=latched id, timeout=flag for one cycle, then IDLE.
- Outside WB, write is all zero; at most one write bit is ever high.
- rsel=0 outside RD_A/RD_B.
- opa, opb and D hold their values until overwritten.
- Minimum latency is 5 cycles from the accepting edge to done: RD_A, RD_B, EXEC (res_valid in the first cycle), WB, DONE.
- A new request is accepted only in IDLE, so back-to-back requests are spaced ≥6 cycles apart.
- A request deasserted before acceptance is not serviced.
- ra=rb=rc is legal; reads return pre-write values.

Optional Feature:
- RR_ARB_EN defined: round-robin arbitration. A pointer records the last-granted requester; when both are valid, the other requester wins. The pointer resets to 1, so requester 0 wins first.
- RR_ARB_EN undefined: fixed priority, requester 0 always wins.

Test Plan:
- Reset mid-WB: clr low during WB -> write=0 immediately, state IDLE, register contents unchanged.
- Req0 ra=3 (R3=0x11), rb=4 (R4=0x22), rc=5, we=1, ALU returns 0x33 first cycle -> rsel=3 then 4, opa=0x11, opb=0x22, write=0x0020 one cycle with D=0x33, done 5 cycles after accept, done_id=0.
- ba=1, ra=0 (R0=0xDEAD) -> BAout=1 in RD_A, opa=0.
- we=0, result 0x7 -> write stays 0, done pulses, D=0x7.
- res_valid never asserted, WAIT_MAX=4 -> done with timeout=1 four cycles into EXEC, write never asserted.
- Both requesters valid continuously for two operations:
  - without RR_ARB_EN -> done_id 0,0;
  - with RR_ARB_EN -> done_id 0,1.
